mmio_bus_mux: RTL and testbench

Parametrised MMIO interconnect between the picorv32 memory port and N memory-mapped cores (TRNG, timer, UDS, UART, touch sense, FW RAM, TK1, …). Decodes the core prefix, drives per-core select/write/address/data, registers read data and ready toward the CPU, and adds what the fixed top-level mux lacks: a firmware-only access mask enforced in app mode, a per-access ready timeout, and a sticky error-address capture. The parent decodes the 2-bit area prefix; `cpu_valid` reaches this block only for MMIO-area accesses.

---
 rtl/mmio_bus_mux.sv | 90 +++++++++
 tb/tb_mmio_bus_mux.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mmio_bus_mux.sv
// mmio_bus_mux: MMIO interconnect from the CPU memory port to NUM_CORES slaves with FW-only mask and error capture.
// Define MMIO_BUS_TIMEOUT_EN to force-complete accesses whose core stays unready for TIMEOUT cycles.
module mmio_bus_mux #(
    parameter int                       NUM_CORES     = 8,
    parameter logic [NUM_CORES*6-1:0]   CORE_PREFIXES = {NUM_CORES{6'h00}},
    parameter logic [NUM_CORES-1:0]     FW_ONLY_MASK  = '0,
    parameter int                       ADDR_W        = 8,
    parameter int                       TIMEOUT       = 64
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    cpu_valid,
    input  logic [31:0]             cpu_addr,
    input  logic [3:0]              cpu_wstrb,
    input  logic [31:0]             cpu_wdata,
    input  logic                    app_mode,
    input  logic                    force_trap,
    output logic                    cpu_ready,
    output logic [31:0]             cpu_rdata,
    output logic                    bus_error,
    output logic [31:0]             err_addr,
    output logic [NUM_CORES-1:0]    core_cs,
    output logic                    core_we,
    output logic [ADDR_W-1:0]       core_address,
    output logic [31:0]             core_write_data,
    input  logic [NUM_CORES*32-1:0] core_read_data,
    input  logic [NUM_CORES-1:0]    core_ready
);
    localparam int IDX_W = NUM_CORES > 1 ? $clog2(NUM_CORES) : 1;
    typedef enum logic {ACCESS, RESP} state_t;
    state_t      state_q, state_d;
    logic        cpu_ready_q, bus_error_q;
    logic [31:0] cpu_rdata_q, err_addr_q;
    logic        hit, masked, cs_en, rdy, tmo, done, err;
    logic [IDX_W-1:0] idx;
    logic [31:0] rdata_d;
    // Scan downward so the lowest matching slot is the one that sticks.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (CORE_PREFIXES[6*i +: 6] == cpu_addr[29:24]) begin
                hit = 1'b1;
                idx = IDX_W'(i);
            end
        end
    end
    assign masked          = FW_ONLY_MASK[idx] & app_mode;
    assign cs_en           = reset_n & (state_q == ACCESS) & cpu_valid & hit & ~masked & ~force_trap;
    assign rdy             = cs_en & core_ready[idx];
    assign core_cs         = cs_en ? NUM_CORES'(1) << idx : '0;
    assign core_we         = |cpu_wstrb;
    assign core_address    = cpu_addr[ADDR_W+1:2];
    assign core_write_data = cpu_wdata;
`ifdef MMIO_BUS_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;
    assign tmo   = cs_en & ~rdy & (cnt_q == 8'(TIMEOUT - 1));
    assign cnt_d = (cs_en & ~rdy & ~tmo) ? cnt_q + 8'd1 : 8'd0;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= 8'd0;
        else          cnt_q <= cnt_d;
    end
`else
    assign tmo = 1'b0;
`endif
    // Any completion that is neither a trap nor a genuine core ready is an error.
    assign done    = (state_q == ACCESS) & cpu_valid & (force_trap | ~hit | masked | rdy | tmo);
    assign err     = ~force_trap & ~rdy;
    assign rdata_d = rdy ? core_read_data[32*idx +: 32] : 32'h0;
    assign state_d = done ? RESP : ACCESS;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ACCESS;
            cpu_ready_q <= 1'b0;
            bus_error_q <= 1'b0;
            cpu_rdata_q <= 32'h0;
            err_addr_q  <= 32'h0;
        end else begin
            state_q     <= state_d;
            cpu_ready_q <= done;
            bus_error_q <= done & err;
            if (done) cpu_rdata_q <= rdata_d;
            if (done & err) err_addr_q <= cpu_addr;
        end
    end
    assign cpu_ready = cpu_ready_q;
    assign bus_error = bus_error_q;
    assign cpu_rdata = cpu_rdata_q;
    assign err_addr  = err_addr_q;
endmodule

// File: tb/tb_mmio_bus_mux.sv
// tb_mmio_bus_mux: table-driven single-access vectors plus hand-written multi-cycle sequences for mmio_bus_mux.
module tb_mmio_bus_mux;
    logic         clk = 1'b0;
    logic         reset_n, cpu_valid, app_mode, force_trap;
    logic [31:0]  cpu_addr, cpu_wdata;
    logic [3:0]   cpu_wstrb;
    logic         cpu_ready, bus_error, core_we;
    logic [31:0]  cpu_rdata, err_addr, core_write_data;
    logic [7:0]   core_cs, core_address, core_ready;
    logic [255:0] core_read_data;
    logic [31:0]  rd [8];
    logic [31:0]  exp_ea;
    int           checks = 0, errors = 0;
    always #5 clk = ~clk;

    mmio_bus_mux #(
        .NUM_CORES(8),
        .CORE_PREFIXES({6'h07, 6'h02, 6'h05, 6'h04, 6'h03, 6'h02, 6'h01, 6'h00}),
        .FW_ONLY_MASK(8'h04),
        .ADDR_W(8),
        .TIMEOUT(16)
    ) dut (
        .clk(clk), .reset_n(reset_n), .cpu_valid(cpu_valid), .cpu_addr(cpu_addr),
        .cpu_wstrb(cpu_wstrb), .cpu_wdata(cpu_wdata), .app_mode(app_mode), .force_trap(force_trap),
        .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata), .bus_error(bus_error), .err_addr(err_addr),
        .core_cs(core_cs), .core_we(core_we), .core_address(core_address),
        .core_write_data(core_write_data), .core_read_data(core_read_data), .core_ready(core_ready)
    );

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic        app;
        logic        trap;
        logic [7:0]  rdy;
        logic        chk_cs;
        logic [7:0]  cs;
        logic        chk_rd;
        logic [31:0] rdata;
        logic        err;
    } vec_t;
    vec_t v [11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        cpu_valid = 1'b0; core_ready = 8'h00; force_trap = 1'b0; app_mode = 1'b0; cpu_wstrb = 4'h0;
    endtask

    task automatic do_vec(input vec_t x);
        cpu_addr = x.addr; cpu_wstrb = x.wstrb; cpu_wdata = x.wdata; app_mode = x.app;
        force_trap = x.trap; core_ready = x.rdy; cpu_valid = 1'b1;
        #1;
        if (x.chk_cs) chk("core_cs", 32'(core_cs), 32'(x.cs));
        chk("core_we", 32'(core_we), 32'(|x.wstrb));
        chk("core_address", 32'(core_address), 32'(x.addr[9:2]));
        chk("core_write_data", core_write_data, x.wdata);
        chk("ready_early", 32'(cpu_ready), 32'h0);
        step();
        if (x.err) exp_ea = x.addr;
        chk("cpu_ready", 32'(cpu_ready), 32'h1);
        if (x.chk_rd) chk("cpu_rdata", cpu_rdata, x.rdata);
        chk("bus_error", 32'(bus_error), 32'(x.err));
        chk("err_addr", err_addr, exp_ea);
        idle();
        step();
        chk("ready_pulse", 32'({cpu_ready, bus_error}), 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) rd[i] = 32'h5A00_0000 + 32'(i);
        rd[2] = 32'hA5A5_0001;
        for (int i = 0; i < 8; i++) core_read_data[32*i +: 32] = rd[i];
        v[0]  = '{32'h0200_0000, 4'h0, 32'h0,         1'b0, 1'b0, 8'h04, 1'b1, 8'h04, 1'b1, 32'hA5A5_0001, 1'b0};
        v[1]  = '{32'hC300_0010, 4'hF, 32'hDEAD_BEEF, 1'b0, 1'b0, 8'h08, 1'b1, 8'h08, 1'b0, 32'h0,         1'b0};
        v[2]  = '{32'h0200_0044, 4'h0, 32'h0,         1'b1, 1'b0, 8'h04, 1'b1, 8'h00, 1'b1, 32'h0,         1'b1};
        v[3]  = '{32'h0300_0008, 4'h0, 32'h0,         1'b1, 1'b0, 8'h08, 1'b1, 8'h08, 1'b1, 32'h5A00_0003, 1'b0};
        v[4]  = '{32'h3E00_0000, 4'h0, 32'h0,         1'b0, 1'b0, 8'hFF, 1'b1, 8'h00, 1'b1, 32'h0,         1'b1};
        v[5]  = '{32'h3E00_0004, 4'h0, 32'h0,         1'b0, 1'b1, 8'hFF, 1'b1, 8'h00, 1'b1, 32'h0,         1'b0};
        v[6]  = '{32'h0100_0000, 4'h0, 32'h0,         1'b0, 1'b1, 8'h02, 1'b0, 8'h00, 1'b1, 32'h0,         1'b0};
        v[7]  = '{32'h0600_0000, 4'h0, 32'h0,         1'b0, 1'b0, 8'hFF, 1'b1, 8'h00, 1'b1, 32'h0,         1'b1};
        v[8]  = '{32'hC000_00FC, 4'h0, 32'h0,         1'b0, 1'b0, 8'h01, 1'b1, 8'h01, 1'b1, 32'h5A00_0000, 1'b0};
        v[9]  = '{32'h0700_03FC, 4'h1, 32'h1234_5678, 1'b0, 1'b0, 8'h80, 1'b1, 8'h80, 1'b0, 32'h0,         1'b0};
        v[10] = '{32'h0400_0000, 4'h0, 32'h0,         1'b1, 1'b0, 8'hFF, 1'b1, 8'h10, 1'b1, 32'h5A00_0004, 1'b0};
        exp_ea = 32'h0;
        cpu_addr = 32'h0; cpu_wdata = 32'h0;
        idle();
        reset_n = 1'b0;
        step();
        chk("rst_out", 32'({cpu_ready, bus_error, core_cs}), 32'h0);
        chk("rst_rdata", cpu_rdata, 32'h0);
        chk("rst_err_addr", err_addr, 32'h0);
        reset_n = 1'b1;
        step();

        for (int i = 0; i < 11; i++) do_vec(v[i]);

        // Ready from an unselected core must not complete the access.
        cpu_addr = 32'h0400_0000; core_ready = 8'h08; cpu_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("unsel_wait", 32'({core_cs, cpu_ready}), 32'({8'h10, 1'b0}));
            step();
        end
        core_ready = 8'h10;
        step();
        chk("unsel_done", 32'({cpu_ready, bus_error}), 32'h2);
        chk("unsel_rdata", cpu_rdata, rd[4]);
        idle();
        step();

`ifdef MMIO_BUS_TIMEOUT_EN
        // Dropping valid mid-wait must restart the count from zero.
        cpu_addr = 32'h0500_0000; cpu_valid = 1'b1;
        repeat (10) step();
        cpu_valid = 1'b0;
        step();
        cpu_valid = 1'b1;
        for (int k = 0; k < 16; k++) begin
            chk("to_wait", 32'({core_cs, cpu_ready}), 32'({8'h20, 1'b0}));
            step();
        end
        exp_ea = 32'h0500_0000;
        chk("to_done", 32'({cpu_ready, bus_error}), 32'h3);
        chk("to_rdata", cpu_rdata, 32'h0);
        chk("to_err_addr", err_addr, exp_ea);
        idle();
        step();
        cpu_addr = 32'h0500_0008; cpu_valid = 1'b1;
        repeat (15) step();
        core_ready = 8'h20;
        step();
        chk("to_ready_wins", 32'({cpu_ready, bus_error}), 32'h2);
        chk("to_ready_rdata", cpu_rdata, rd[5]);
        chk("to_ready_ea", err_addr, exp_ea);
        idle();
        step();
`else
        begin
            logic seen;
            seen = 1'b0;
            cpu_addr = 32'h0500_0000; cpu_valid = 1'b1;
            repeat (1000) begin
                step();
                if (cpu_ready) seen = 1'b1;
            end
            chk("no_timeout", 32'(seen), 32'h0);
            core_ready = 8'h20;
            step();
            chk("late_ready", 32'({cpu_ready, bus_error}), 32'h2);
            chk("late_rdata", cpu_rdata, rd[5]);
            idle();
            step();
        end
`endif

        // Asynchronous reset at select cycle 3 clears everything at once.
        cpu_addr = 32'h0500_0000; cpu_valid = 1'b1;
        repeat (3) step();
        chk("pre_rst_cs", 32'(core_cs), 32'h20);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_out", 32'({cpu_ready, bus_error, core_cs}), 32'h0);
        chk("mid_rst_rdata", cpu_rdata, 32'h0);
        chk("mid_rst_ea", err_addr, 32'h0);
        exp_ea = 32'h0;
        idle();
        step();
        chk("rst_no_ready", 32'(cpu_ready), 32'h0);
        reset_n = 1'b1;
        step();
        do_vec(v[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
